kernel_harness: RTL and testbench
=================================

# kernel_harness

Synthesizable host-side harness for one compiled kernel (`main`). It owns the kernel's single array as an on-chip memory, preloads and reads back that memory over a host port, and launches the kernel with a one-cycle `r_enable` pulse. It captures `result` on `w_enable` and reports completion, latency and timeout. It replaces testbench-only launch logic, so a kernel can be run repeatedly on hardware with configurable result, init and array widths.

## Interface

- `RESULT_W`, 2: kernel result width
- `INIT_W`, 1: kernel `init_i` width
- `DATA_W`, 1: array word width
- `ADDR_W`, 1: array address width; depth = 2**ADDR_W
- `CNT_W`, 16: latency counter width
- `TIMEOUT`, 1000: watchdog limit in RUN cycles (only with watchdog compiled in)

Ports:

- `clk` in 1: clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: launch request; sampled only in IDLE
- `init_in` in INIT_W: value latched into `init_i` at launch
- `host_we` in 1: array write; honoured only in IDLE
- `host_addr` in ADDR_W: host array address
- `host_wdata` in DATA_W: host write data
- `host_rdata` out DATA_W: host read data, one cycle after address
- `busy` out 1: high in LAUNCH, RUN and DONE
- `done` out 1: one-cycle completion pulse
- `timed_out` out 1: the last run ended by watchdog; held until next launch
- `result_out` out RESULT_W: captured result; held until next launch
- `cycles` out CNT_W: latency of the last run; held until next launch
- `r_enable` out 1: kernel start pulse
- `init_i` out INIT_W: kernel argument
- `w_enable` in 1: kernel finished
- `result` in RESULT_W: kernel result, valid with `w_enable`
- `arr_addr` in ADDR_W: kernel array address
- `arr_wenable` in 1: kernel array write
- `arr_wdata` in DATA_W: kernel write data
- `arr_rdata` out DATA_W: kernel read data, one cycle after address

## Operation

- FSM states are IDLE, LAUNCH, RUN and DONE. Reset enters IDLE.
- IDLE → LAUNCH when `start`=1. In LAUNCH, `r_enable`=1, `init_i`←`init_in`, `cycles`←0, `timed_out`←0, `result_out`←0.
- LAUNCH → RUN unconditionally.
- In RUN, `cycles` increments each cycle and saturates at 2**CNT_W−1. `w_enable` is sampled only in RUN. On `w_enable`=1, `result_out`←`result` and the state goes to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Memory: single array, DEPTH×DATA_W, with registered read.
  - The port is owned by the host in IDLE and by the kernel in LAUNCH/RUN/DONE.
  - The non-owner's write is ignored. The non-owner's rdata reads the shared registered output, which is don't-care for that side.
- Memory contents are not reset. They persist across runs and across `rst`.
- `start` outside IDLE is ignored and not queued.
- A `w_enable` outside RUN is ignored.
- A `w_enable` in the same cycle as a kernel write: the write completes, then the state enters DONE.
- Reset mid-run: next cycle is IDLE. `r_enable`, `done`, `busy`, `timed_out` = 0; `result_out`, `cycles` = 0; `init_i` = 0.

## Timing

- `start` high at edge T0 → `r_enable` high in cycle T0..T1 (LAUNCH). RUN starts at T1.
- A kernel asserting `w_enable` in the k-th RUN cycle → `cycles`=k and `done` high in the following cycle. `result_out` is valid in the same cycle as `done`.
- Launch-to-`done` latency is k+2 cycles.
- Host read: address at edge T → `host_rdata` valid after T+1. A read and write to the same address in the same cycle returns old data. The same holds for the kernel port.
- `busy` rises one cycle after `start` is sampled and falls one cycle after `done`.
- Back-to-back: `start` held high relaunches in the cycle after DONE returns to IDLE, i.e. one idle cycle between runs.

## Configuration

- `KERNEL_HARNESS_WATCHDOG_EN` defined:
  - In RUN, when `cycles` reaches TIMEOUT without `w_enable`, the state goes to DONE with `timed_out`=1, `result_out`=0, `cycles`=TIMEOUT.
  - `w_enable` in the same cycle as the limit wins: normal completion, `timed_out`=0.
- Not defined: no watchdog logic. `timed_out` is tied to 0 and RUN waits indefinitely.

## Test plan

- Reset, idle 5 cycles → all outputs 0, `busy`=0.
- Host writes [1,0] to addresses 0,1, then reads address 1 → `host_rdata`=0 one cycle later. Writes issued while `busy` leave contents unchanged.
- `init_in`=0; stub kernel asserts `w_enable` with `result`=2 in its 3rd RUN cycle → `r_enable` is a single-cycle pulse, `init_i`=0, `done` one cycle, `result_out`=2, `cycles`=3.
- Stub kernel writes 1 to address 0 during RUN; after `done`, host reads address 0 → 1. `start` pulses during RUN produce no second launch.
- `rst` asserted in RUN cycle 2 → IDLE next cycle, outputs zeroed, array contents intact. A fresh `start` then runs normally.
- With `KERNEL_HARNESS_WATCHDOG_EN` and TIMEOUT=8, kernel never responds → `done` after 8 RUN cycles, `timed_out`=1, `result_out`=0, `cycles`=8.

Source files
------------

// File: rtl/kernel_harness.sv
// kernel_harness: host-side launch/capture harness for one compiled kernel.
// Owns the kernel's single array (registered read), launches the kernel with
// a one-cycle r_enable pulse, captures result on w_enable and reports
// completion, latency and (optionally) watchdog timeout.
// Optional watchdog: define KERNEL_HARNESS_WATCHDOG_EN to compile it in.
module kernel_harness #(
  parameter int unsigned RESULT_W = 2,
  parameter int unsigned INIT_W   = 1,
  parameter int unsigned DATA_W   = 1,
  parameter int unsigned ADDR_W   = 1,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned TIMEOUT  = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [INIT_W-1:0]   init_in,
  input  logic                host_we,
  input  logic [ADDR_W-1:0]   host_addr,
  input  logic [DATA_W-1:0]   host_wdata,
  output logic [DATA_W-1:0]   host_rdata,
  output logic                busy,
  output logic                done,
  output logic                timed_out,
  output logic [RESULT_W-1:0] result_out,
  output logic [CNT_W-1:0]    cycles,
  output logic                r_enable,
  output logic [INIT_W-1:0]   init_i,
  input  logic                w_enable,
  input  logic [RESULT_W-1:0] result,
  input  logic [ADDR_W-1:0]   arr_addr,
  input  logic                arr_wenable,
  input  logic [DATA_W-1:0]   arr_wdata,
  output logic [DATA_W-1:0]   arr_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_DONE} state_t;

  state_t              state_q;
  logic                busy_q;
  logic                done_q;
  logic                r_enable_q;
  logic [INIT_W-1:0]   init_q;
  logic [RESULT_W-1:0] result_q;
  logic [CNT_W-1:0]    cycles_q;
  logic [CNT_W-1:0]    cycles_d;

  logic [DATA_W-1:0]   mem_q [2**ADDR_W];
  logic [DATA_W-1:0]   rdata_q;
  logic                host_own;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;

`ifdef KERNEL_HARNESS_WATCHDOG_EN
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  logic timed_out_q;
`endif

  // Saturating next value of the latency counter.
  always_comb begin
    cycles_d = cycles_q;
    if (!(&cycles_q)) cycles_d = cycles_q + 1'b1;
  end

  // Launch/run/complete sequencing with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      r_enable_q <= 1'b0;
      init_q     <= '0;
      result_q   <= '0;
      cycles_q   <= '0;
`ifdef KERNEL_HARNESS_WATCHDOG_EN
      timed_out_q <= 1'b0;
`endif
    end else begin
      r_enable_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_LAUNCH;
            busy_q     <= 1'b1;
            r_enable_q <= 1'b1;
            init_q     <= init_in;
            result_q   <= '0;
            cycles_q   <= '0;
`ifdef KERNEL_HARNESS_WATCHDOG_EN
            timed_out_q <= 1'b0;
`endif
          end
        end
        S_LAUNCH: state_q <= S_RUN;
        S_RUN: begin
          cycles_q <= cycles_d;
          if (w_enable) begin
            result_q <= result;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
`ifdef KERNEL_HARNESS_WATCHDOG_EN
          // A kernel response on the limit cycle takes priority above.
          else if (cycles_d == TIMEOUT_C) begin
            timed_out_q <= 1'b1;
            done_q      <= 1'b1;
            state_q     <= S_DONE;
          end
`endif
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Single array port: host owns it in IDLE, the kernel otherwise.
  always_comb begin
    host_own  = (state_q == S_IDLE);
    mem_we    = host_own ? host_we    : arr_wenable;
    mem_addr  = host_own ? host_addr  : arr_addr;
    mem_wdata = host_own ? host_wdata : arr_wdata;
  end

  // Array storage with registered read (read-before-write); never reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_addr] <= mem_wdata;
    rdata_q <= mem_q[mem_addr];
  end

  assign host_rdata = rdata_q;
  assign arr_rdata  = rdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign r_enable   = r_enable_q;
  assign init_i     = init_q;
  assign result_out = result_q;
  assign cycles     = cycles_q;
`ifdef KERNEL_HARNESS_WATCHDOG_EN
  assign timed_out  = timed_out_q;
`else
  assign timed_out  = 1'b0;
`endif

endmodule

// File: tb/tb_kernel_harness.sv
`define CHK(tag, o, e) check(tag, 32'(o), 32'(e))
module tb_kernel_harness;
  localparam int RW = 8, IW = 4, DW = 8, AW = 3, CW = 4, TO = 8, DEPTH = 8;
  localparam int CMAX = 15;
`ifdef KERNEL_HARNESS_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [IW-1:0] init_in;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic [DW-1:0] host_rdata;
  logic          busy, done, timed_out, r_enable;
  logic [RW-1:0] result_out;
  logic [CW-1:0] cycles;
  logic [IW-1:0] init_i;
  logic          w_enable;
  logic [RW-1:0] result;
  logic [AW-1:0] arr_addr;
  logic          arr_wenable;
  logic [DW-1:0] arr_wdata;
  logic [DW-1:0] arr_rdata;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] ref_mem [DEPTH];

  kernel_harness #(
    .RESULT_W(RW), .INIT_W(IW), .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .init_in(init_in),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .busy(busy), .done(done), .timed_out(timed_out),
    .result_out(result_out), .cycles(cycles), .r_enable(r_enable), .init_i(init_i),
    .w_enable(w_enable), .result(result), .arr_addr(arr_addr),
    .arr_wenable(arr_wenable), .arr_wdata(arr_wdata), .arr_rdata(arr_rdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if ((r_enable & ~busy) !== 1'b0) begin
        errors++;
        $error("FAIL mon_renable_busy: r_enable=%b busy=%b", r_enable, busy);
      end
      checks++;
      if ((done & ~busy) !== 1'b0) begin
        errors++;
        $error("FAIL mon_done_busy: done=%b busy=%b", done, busy);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input int a, input logic [DW-1:0] d);
    host_addr = AW'(a); host_wdata = d; host_we = 1'b1;
    tick();
    host_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic host_rd(input string tag, input int a);
    host_addr = AW'(a);
    tick();
    `CHK(tag, host_rdata, ref_mem[a]);
  endtask

  task automatic check_mem();
    for (int i = 0; i < DEPTH; i++) host_rd("mem_readback", i);
  endtask

  task automatic check_quiet(input string tag);
    `CHK({tag, "_busy"}, busy, 0);
    `CHK({tag, "_done"}, done, 0);
    `CHK({tag, "_renable"}, r_enable, 0);
    `CHK({tag, "_timedout"}, timed_out, 0);
    `CHK({tag, "_result"}, result_out, 0);
    `CHK({tag, "_cycles"}, cycles, 0);
    `CHK({tag, "_init"}, init_i, 0);
  endtask

  task automatic run(input int k, input logic [RW-1:0] res, input logic [IW-1:0] ini,
                     input bit kwrite, input int kaddr, input logic [DW-1:0] kdata,
                     input bit hold);
    bit            exp_to;
    int            run_len, exp_cyc, prev_a;
    logic [RW-1:0] exp_res;
    exp_to  = WD && (k > TO);
    run_len = exp_to ? TO : k;
    exp_cyc = exp_to ? TO : ((k > CMAX) ? CMAX : k);
    exp_res = exp_to ? '0 : res;

    start = 1'b1; init_in = ini; host_we = 1'b0;
    tick();
    start = 1'b0; w_enable = 1'b1; result = '1;
    `CHK("launch_renable", r_enable, 1);
    `CHK("launch_busy", busy, 1);
    `CHK("launch_init", init_i, ini);
    `CHK("launch_cycles", cycles, 0);
    `CHK("launch_result", result_out, 0);
    `CHK("launch_timedout", timed_out, 0);
    `CHK("launch_done", done, 0);
    prev_a = int'($urandom_range(DEPTH - 1));
    arr_addr = AW'(prev_a); arr_wenable = 1'b0;
    tick();
    w_enable = 1'b0;
    for (int n = 1; n <= run_len; n++) begin
      `CHK("run_cycles", cycles, (n - 1 > CMAX) ? CMAX : n - 1);
      `CHK("run_busy", busy, 1);
      `CHK("run_done", done, 0);
      `CHK("run_renable", r_enable, 0);
      `CHK("kern_read", arr_rdata, ref_mem[prev_a]);
      start = 1'($urandom_range(1));
      host_we = 1'b1; host_addr = AW'($urandom); host_wdata = DW'($urandom);
      if (n == k) begin
        w_enable = 1'b1; result = res;
      end
      if (n == k && kwrite) begin
        prev_a = kaddr; arr_addr = AW'(kaddr); arr_wenable = 1'b1; arr_wdata = kdata;
      end else begin
        prev_a = int'($urandom_range(DEPTH - 1)); arr_addr = AW'(prev_a);
      end
      tick();
      w_enable = 1'b0; arr_wenable = 1'b0; host_we = 1'b0; start = 1'b0;
    end
    `CHK("done_pulse", done, 1);
    `CHK("done_busy", busy, 1);
    `CHK("done_result", result_out, exp_res);
    `CHK("done_cycles", cycles, exp_cyc);
    `CHK("done_timedout", timed_out, exp_to);
    `CHK("done_renable", r_enable, 0);
    `CHK("kern_read_old", arr_rdata, ref_mem[prev_a]);
    if (kwrite && !exp_to) ref_mem[kaddr] = kdata;
    start = hold; w_enable = 1'b1; result = 8'hEE;
    tick();
    w_enable = 1'b0;
    `CHK("post_done", done, 0);
    `CHK("post_busy", busy, 0);
    `CHK("post_renable", r_enable, 0);
    `CHK("held_result", result_out, exp_res);
    `CHK("held_cycles", cycles, exp_cyc);
    `CHK("held_timedout", timed_out, exp_to);
  endtask

  initial begin
    logic [DW-1:0] old_d;
    rst = 1'b1; start = 1'b0; init_in = '0; host_we = 1'b0; host_addr = '0;
    host_wdata = '0; w_enable = 1'b0; result = '0; arr_addr = '0;
    arr_wenable = 1'b0; arr_wdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    check_quiet("reset");

    for (int i = 0; i < DEPTH; i++) host_wr(i, DW'($urandom));
    host_wr(0, 8'd1);
    host_wr(1, 8'd0);
    host_rd("host_rd_addr1", 1);

    old_d = ref_mem[5];
    host_addr = 3'd5; host_wdata = ~old_d; host_we = 1'b1;
    tick();
    host_we = 1'b0;
    `CHK("host_rdw_old", host_rdata, old_d);
    ref_mem[5] = ~old_d;
    host_rd("host_rdw_new", 5);

    host_wr(0, 8'd0);
    run(3, 8'd2, 4'd0, 1'b1, 0, 8'd1, 1'b0);
    host_rd("kern_wrote_addr0", 0);
    check_mem();

    run(1, 8'h5A, 4'hF, 1'b0, 0, 8'd0, 1'b0);
    run(TO, 8'hC3, 4'h9, 1'b1, 7, 8'hA5, 1'b0);
    run(20, 8'h77, 4'h3, 1'b1, 2, 8'h3C, 1'b0);
    check_mem();

    start = 1'b1; init_in = 4'h5;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_quiet("midrun_reset");
    check_mem();
    run(4, 8'h11, 4'h6, 1'b0, 0, 8'd0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      run(int'($urandom_range(12, 1)), RW'($urandom), IW'($urandom),
          1'($urandom_range(1)), int'($urandom_range(DEPTH - 1)), DW'($urandom),
          (r < 7) ? 1'($urandom_range(1)) : 1'b0);
    end
    start = 1'b0;
    tick();
    `CHK("final_idle_busy", busy, 0);
    check_mem();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
